alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor of the team's 4-bit combinational ALU (add/sub/compare/AND behind a 2-bit select decoder).
- Generalises to WIDTH-bit operands and a 3-bit opcode.
- Adds OR/XOR and an iterative shift-add multiply.
- Wraps all operations in a valid/ready handshake with a single output holding register.
- Sits between the operand/opcode source and the result consumer; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2 to 32).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  source presents a valid op/a/b.
- in_ready  output  1  block accepts the operation this cycle.
- op  input  3  opcode: 000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 reserved.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  primary result; MUL low half.
- result_hi  output  WIDTH  MUL high half; 0 for all other ops.
- carry  output  1  ADD carry-out; SUB no-borrow (1 when a>=b); MUL 1 when result_hi!=0; else 0.
- a_gt_b  output  1  comparison flag, valid for CMP only, else 0.
- a_eq_b  output  1  comparison flag, valid for CMP only, else 0.
- a_lt_b  output  1  comparison flag, valid for CMP only, else 0.
- zero  output  1  result==0 (and result_hi==0 for MUL).
- illegal  output  1  op was 111.
- busy  output  1  multiply in progress.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; out_valid=0; result, result_hi, carry, all flags, illegal, busy=0; internal accumulators and counter cleared. An operation in flight is discarded, with no partial output.
- States:
  - IDLE: no operation in flight.
  - MUL: multiply iterating.
  - HOLD: result registered, waiting for the consumer.
- in_ready = (state==IDLE) or (state==HOLD and out_ready). Accept occurs when in_valid and in_ready.
- Single-cycle ops (ADD, SUB, CMP, AND, OR, XOR, 111):
  - Result is registered on the accept edge; out_valid=1 the next cycle (latency 1). Next state HOLD.
  - ADD: {carry,result} = a+b, (WIDTH+1)-bit; wraps modulo 2^WIDTH.
  - SUB: result = a + ~b + 1 (two's complement wrap); carry as defined in Ports.
  - CMP: result=0, carry=0; exactly one of gt/eq/lt set, unsigned compare; zero=1.
  - AND/OR/XOR: bitwise; carry=0.
  - 111: result=0, result_hi=0, illegal=1, zero=1; illegal ops are not dropped.
- MUL:
  - On accept, latch a and b, clear the product, counter=0, busy=1, state MUL.
  - Each MUL cycle: if multiplier LSB is 1, add the multiplicand to the upper half; shift the 2*WIDTH product right; counter+1.
  - After WIDTH iterations, load {result_hi,result} = a*b and set out_valid, carry, zero; busy=0; state HOLD.
  - Total latency is WIDTH+1 cycles from the accept edge to out_valid=1.
  - in_ready=0 throughout MUL. Operands changing during MUL have no effect.
- HOLD:
  - Outputs are stable while out_valid=1 and out_ready=0 (no overwrite).
  - out_ready=1 with no new accept: out_valid drops next cycle, state IDLE; output data is retained but don't-care.
  - out_ready=1 and simultaneous accept (back-to-back): result is consumed and the new op launched in the same cycle.
    - Single-cycle op: new result appears next cycle with out_valid staying 1.
    - MUL: out_valid drops to 0 next cycle and busy=1.
- Flags not meaningful for the current op are driven 0. The flags are registered together with result.
- Throughput: one single-cycle op per clock when out_ready is held high.

Test Plan:
- Reset: assert rst mid-MUL (cycle 3 of 8). Required: out_valid, busy, result, flags = 0 immediately (asynchronous); in_ready=1 after release; no stale result appears.
- ADD/SUB wrap, WIDTH=8:
  - ADD a=0xF0, b=0x20 -> result=0x10, carry=1, latency 1.
  - SUB a=0x05, b=0x07 -> result=0xFE, carry=0.
  - SUB a=0x07, b=0x07 -> result=0x00, carry=1, zero=1.
- CMP and logic:
  - CMP 0x80 vs 0x7F -> a_gt_b=1 only.
  - CMP 0x33 vs 0x33 -> a_eq_b=1.
  - XOR 0xAA, 0xFF -> result=0x55.
  - op=111 -> illegal=1, result=0.
- MUL:
  - a=0xFF, b=0xFF -> result=0x01, result_hi=0xFE, carry=1, out_valid exactly 9 cycles after accept; in_ready=0 and busy=1 throughout.
  - a=0, b=0x12 -> zero=1, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD result. Required: result and flags stable, in_ready=0, a second in_valid is not accepted; on release the second op is accepted on the same edge.
- Streaming: 16 random single-cycle ops with in_valid=1 and out_ready=1 -> one result per cycle, in order, matching the scoreboard; then a random MUL mid-stream stalls in_ready for exactly WIDTH+1 cycles.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU behind a valid/ready handshake.
// Single-cycle ops (ADD/SUB/CMP/AND/OR/XOR/illegal) land in the output
// register on the accept edge; MUL iterates shift-add for WIDTH cycles and
// loads the full 2*WIDTH-bit product one cycle after the last iteration.
// Only one operation is in flight; the output register doubles as the
// hand-off buffer toward the consumer.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  // Flags travel together with the result word.
  typedef struct packed {
    logic carry;
    logic gt;
    logic eq;
    logic lt;
    logic zero;
    logic illegal;
  } flags_t;

  logic [1:0]         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  flags_t             flg_q, flg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   sc_res;
  flags_t             sc_flg;
  logic [WIDTH:0]     acc_sum;
  logic [2*WIDTH-1:0] prod_step;
  logic               accept;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath: result and flags for every non-MUL opcode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    sc_res   = '0;
    sc_flg   = '0;
    case (op)
      OP_ADD: begin
        sc_res       = sum_ext[WIDTH-1:0];
        sc_flg.carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        sc_res       = diff_ext[WIDTH-1:0];
        sc_flg.carry = diff_ext[WIDTH];   // no-borrow: set when a >= b
      end
      OP_CMP: begin
        sc_flg.gt = (a > b);
        sc_flg.eq = (a == b);
        sc_flg.lt = (a < b);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_MUL:  sc_res = '0;               // handled by the iterative path
      default: sc_flg.illegal = 1'b1;     // 111: reported, not dropped
    endcase
    sc_flg.zero = (sc_res == '0);
  end

  // One shift-add multiply step: conditionally add, then shift right.
  always_comb begin
    acc_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step = {acc_sum, prod_q[WIDTH-1:1]};
  end

  // Control FSM and next-value selection for the output register.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    res_d       = res_q;
    hi_d        = hi_q;
    flg_d       = flg_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: ;
      S_MUL: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          res_d       = prod_q[WIDTH-1:0];
          hi_d        = prod_q[2*WIDTH-1:WIDTH];
          flg_d       = '0;
          flg_d.carry = (prod_q[2*WIDTH-1:WIDTH] != '0);
          flg_d.zero  = (prod_q == '0);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_HOLD;
        end else begin
          prod_d   = prod_step;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new accept overrides the HOLD drain above (back-to-back launch).
    if (accept) begin
      if (op == OP_MUL) begin
        mcand_d     = a;
        mplier_d    = b;
        prod_d      = '0;
        cnt_d       = '0;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
        state_d     = S_MUL;
      end else begin
        res_d       = sc_res;
        hi_d        = '0;
        flg_d       = sc_flg;
        out_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
      hi_q        <= '0;
      flg_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      res_q       <= res_d;
      hi_q        <= hi_d;
      flg_q       <= flg_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign carry     = flg_q.carry;
  assign a_gt_b    = flg_q.gt;
  assign a_eq_b    = flg_q.eq;
  assign a_lt_b    = flg_q.lt;
  assign zero      = flg_q.zero;
  assign illegal   = flg_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=8). Expected results are
// pushed when an operation is accepted and popped when the consumer takes
// the result; a behavioural model produces every expected value.
module tb_alu_seq;

  localparam int W = 8;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] CMP = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] XOR = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] ILL = 3'b111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, a_gt_b, a_eq_b, a_lt_b;
  logic         zero, illegal, busy;
  logic [W-1:0] result, result_hi;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  // lat = clock edges from the accept edge until out_valid is seen high.
  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic c, gt, eq, lt, z, il;
    int   acc;
    int   lat;
  } exp_t;

  exp_t sb[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry(carry),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .zero(zero),
    .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [2*W-1:0] p;
    e.res = '0; e.hi = '0;
    e.c = 0; e.gt = 0; e.eq = 0; e.lt = 0; e.il = 0;
    e.acc = 0; e.lat = 0;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      ADD: {e.c, e.res} = {1'b0, x} + {1'b0, y};
      SUB: begin e.res = x - y; e.c = (x >= y); end
      CMP: begin e.gt = (x > y); e.eq = (x == y); e.lt = (x < y); end
      AND: e.res = x & y;
      OR:  e.res = x | y;
      XOR: e.res = x ^ y;
      MUL: begin
        e.res = p[W-1:0]; e.hi = p[2*W-1:W];
        e.c = (e.hi != '0); e.lat = W + 1;
      end
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == '0) && (e.hi == '0);
    return e;
  endfunction

  task automatic drive(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
  endtask

  // Waits for acceptance, pushes the expectation, returns cycles stalled.
  task automatic wait_accept(output int stall);
    exp_t e;
    bit   done;
    done  = 0;
    stall = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(op, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        done = 1;
      end else begin
        stall++;
      end
    end
    if (!done) check("accept_timeout", 0, 1);
    else begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int s;
    drive(o, x, y);
    wait_accept(s);
  endtask

  // Output monitor: compares every visible result against the queue head.
  exp_t m_e;
  bit   prev_valid = 0;
  bit   prev_taken = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      prev_taken = 0;
    end else begin
      if (out_valid) begin
        check("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          m_e = sb[0];
          if (!prev_valid || prev_taken) check("latency", cyc - m_e.acc, m_e.lat);
          check("sb_result", result, m_e.res);
          check("sb_result_hi", result_hi, m_e.hi);
          check("sb_flags", {carry, a_gt_b, a_eq_b, a_lt_b, zero, illegal},
                {m_e.c, m_e.gt, m_e.eq, m_e.lt, m_e.z, m_e.il});
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_valid = out_valid;
      prev_taken = out_valid && out_ready;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    exp_t e1, e2;
    logic [2:0] o;

    // Reset state
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", {result_hi, result}, 0);
    check("rst_flags", {carry, a_gt_b, a_eq_b, a_lt_b, zero, illegal}, 0);
    rst = 1'b0;
    #1 check("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed single-cycle ops
    send(ADD, 8'hF0, 8'h20);
    check("add_result", result, 8'h10);
    check("add_carry", carry, 1);
    send(SUB, 8'h05, 8'h07);
    check("sub_result", result, 8'hFE);
    check("sub_carry", carry, 0);
    send(SUB, 8'h07, 8'h07);
    check("sub_eq_flags", {carry, zero, result}, {1'b1, 1'b1, 8'h00});
    send(CMP, 8'h80, 8'h7F);
    check("cmp_gt", {a_gt_b, a_eq_b, a_lt_b, zero}, 4'b1001);
    send(CMP, 8'h33, 8'h33);
    check("cmp_eq", {a_gt_b, a_eq_b, a_lt_b, zero}, 4'b0101);
    send(XOR, 8'hAA, 8'hFF);
    check("xor_result", result, 8'h55);
    send(ILL, 8'h5A, 8'h3C);
    check("ill_flags", {illegal, zero, result, result_hi}, {1'b1, 1'b1, 16'h0000});

    // MUL 0xFF*0xFF, per-cycle handshake view; operands scrambled mid-flight
    send(MUL, 8'hFF, 8'hFF);
    a = W'($urandom); b = W'($urandom);
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      if (k <= W) begin
        check("mul_wait_valid", out_valid, 0);
        check("mul_wait_busy", busy, 1);
        check("mul_wait_ready", in_ready, 0);
      end else begin
        check("mul_done_valid", out_valid, 1);
        check("mul_done_busy", busy, 0);
        check("mul_ff_product", {result_hi, result, carry}, {8'hFE, 8'h01, 1'b1});
      end
    end
    @(posedge clk); #1;

    // MUL by zero
    send(MUL, 8'h00, 8'h12);
    repeat (W + 2) @(negedge clk);
    check("mul0_valid", out_valid, 1);
    check("mul0_flags", {zero, carry}, 2'b10);
    @(posedge clk); #1;

    // Reset mid-MUL (third iteration)
    send(MUL, W'($urandom), W'($urandom));
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("amid_out_valid", out_valid, 0);
    check("amid_busy", busy, 0);
    check("amid_result", {result_hi, result}, 0);
    check("amid_flags", {carry, a_gt_b, a_eq_b, a_lt_b, zero, illegal}, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 check("amid_in_ready", in_ready, 1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // Backpressure: ADD result held 5 cycles, second op waits
    out_ready = 1'b0;
    e1 = model(ADD, 8'hC3, 8'h5E);
    send(ADD, 8'hC3, 8'h5E);
    e2 = model(SUB, 8'h19, 8'h84);
    drive(SUB, 8'h19, 8'h84);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", result, e1.res);
      check("bp_flags", {carry, zero}, {e1.c, e1.z});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept(s);
    check("bp_release_stall", s, 0);
    check("bp_second_valid", out_valid, 1);
    check("bp_second_result", {result, carry}, {e2.res, e2.c});

    // Streaming single-cycle ops, one per clock
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 6));
      if (o == MUL) o = ILL;
      drive(o, W'($urandom), W'($urandom));
      wait_accept(s);
      check("stream_stall", s, 0);
    end
    drive(MUL, W'($urandom), W'($urandom));
    wait_accept(s);
    check("b2b_mul_stall", s, 0);
    check("b2b_mul_state", {out_valid, busy}, 2'b01);
    drive(3'($urandom_range(0, 5)), W'($urandom), W'($urandom));
    wait_accept(s);
    check("mul_stall_len", s, W + 1);
    for (int i = 0; i < 4; i++) begin
      drive(3'($urandom_range(0, 5)), W'($urandom), W'($urandom));
      wait_accept(s);
      check("stream_tail_stall", s, 0);
    end

    // Drain
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
